// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle between an interconnect slave port and a memory slave.
// The master drives the request side; the slave returns data and handshake.
interface wb_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   ADR;
  logic [2:0]                 CTI;
  logic [1:0]                 BTE;
  logic [WB_DATA_WIDTH-1:0]   DAT_W;
  logic [WB_DATA_WIDTH-1:0]   DAT_R;
  logic                       CYC;
  logic [WB_DATA_WIDTH/8-1:0] SEL;
  logic                       STB;
  logic                       WE;
  logic                       ACK;
  logic                       ERR;

  modport master (
    output ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave around a synchronous-read single-port SRAM, supporting
// classic cycles plus registered-feedback incrementing and wrapping bursts.
module wb_sram_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  s
);
  localparam int LB    = $clog2(WB_DATA_WIDTH / 8);
  localparam int NL    = WB_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  state_t                     state_q;
  logic [MEM_ADDR_BITS-1:0]   addr_q;
  logic [MEM_ADDR_BITS-1:0]   addr_d;
  logic [MEM_ADDR_BITS-1:0]   rd_addr;
  logic [MEM_ADDR_BITS-1:0]   word_adr;
  logic [1:0]                 bte_q;
  logic [WB_DATA_WIDTH-1:0]   dat_r_q;
  logic                       req;
  logic                       ack;
  logic                       unused_adr;
  logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];

  // Wrapping keeps the upper address bits and cycles the low 2/3/4 bits.
  function automatic logic [MEM_ADDR_BITS-1:0] next_addr(
    input logic [MEM_ADDR_BITS-1:0] a,
    input logic [1:0]               bte
  );
    logic [MEM_ADDR_BITS-1:0] inc;
    logic [MEM_ADDR_BITS-1:0] mask;
    inc = a + MEM_ADDR_BITS'(1);
    case (bte)
      2'b01:   mask = MEM_ADDR_BITS'(3);
      2'b10:   mask = MEM_ADDR_BITS'(7);
      2'b11:   mask = MEM_ADDR_BITS'(15);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign word_adr   = s.ADR[MEM_ADDR_BITS+LB-1:LB];
  assign unused_adr = ^s.ADR;
  assign req        = s.CYC && s.STB;
  assign ack        = (state_q != IDLE) && req;

  always_comb begin
    addr_d = addr_q;
    case (state_q)
      IDLE:    if (req) addr_d = word_adr;
      BURST:   if (ack) addr_d = next_addr(addr_q, bte_q);
      default: addr_d = addr_q;
    endcase
  end

  // Read one cycle ahead so the registered output lines up with ACK.
  assign rd_addr = (state_q == IDLE) ? word_adr : addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bte_q   <= 2'b00;
      dat_r_q <= '0;
    end else begin
      addr_q  <= addr_d;
      dat_r_q <= mem[rd_addr];
      case (state_q)
        IDLE: begin
          if (req) begin
            bte_q   <= s.BTE;
            state_q <= (s.CTI == 3'b010) ? BURST : SINGLE;
          end
        end
        SINGLE: state_q <= IDLE;
        BURST: begin
          if (!s.CYC)                         state_q <= IDLE;
          else if (ack && s.CTI == 3'b111)    state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ack && s.WE) begin
      for (int i = 0; i < NL; i++) begin
        if (s.SEL[i]) mem[addr_q][8*i +: 8] <= s.DAT_W[8*i +: 8];
      end
    end
  end

  assign s.ACK   = ack;
  assign s.ERR   = 1'b0;
  assign s.DAT_R = dat_r_q;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: random classic and burst traffic against a word-array
// memory model with burst addresses computed arithmetically.
module tb_wb_sram_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_if #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus ();

  wb_sram_slave #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .MEM_ADDR_BITS(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [1024];
  int          b_cyc [16];
  logic [31:0] b_rd  [16];
  logic [31:0] b_wd  [16];
  int          b_got;

  function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] sel);
    for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Word of beat k: linear counts modulo depth, wrapping stays in an aligned block.
  function automatic int burst_word(input int start, input int bte, input int k);
    int len;
    if (bte == 0) return (start + k) % 1024;
    len = 2 << bte;
    return start - (start % len) + ((start % len) + k) % len;
  endfunction

  task automatic bus_idle();
    bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.CTI = 3'b000;
    bus.BTE = 2'b00; bus.SEL = 4'h0; bus.ADR = '0; bus.DAT_W = '0;
  endtask

  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = we; bus.ADR = adr;
    bus.DAT_W = dat; bus.SEL = sel; bus.CTI = 3'b000; bus.BTE = 2'b00;
    lat = -1; rdata = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.ACK === 1'b1) begin lat = c; rdata = bus.DAT_R; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus_idle();
    if (we && lat >= 0) model_write(int'(adr[11:2]), dat, sel);
  endtask

  task automatic burst(input logic we, input int start, input int bte, input int n,
                       input int wait_cyc, input int stop_after);
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.WE = we; bus.BTE = 2'(bte); bus.SEL = 4'hF;
    b_got = 0;
    for (int c = 0; c < 40 && b_got < stop_after; c++) begin
      bus.STB   = (c != wait_cyc);
      bus.CTI   = (b_got == n - 1) ? 3'b111 : 3'b010;
      bus.DAT_W = b_wd[b_got];
      bus.ADR   = 32'(burst_word(start, bte, b_got) * 4);
      @(negedge clk);
      if (bus.ACK === 1'b1) begin
        b_cyc[b_got] = c;
        b_rd[b_got]  = bus.DAT_R;
        if (we) ref_mem[burst_word(start, bte, b_got)] = b_wd[b_got];
        b_got++;
      end
      @(posedge clk); #1;
    end
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    bus_idle();
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.CTI = 3'b010;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ACK); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
    checks++; if (bus.DAT_R !== 32'h0) begin errors++; $display("FAIL reset_datr: got %h expected 0", bus.DAT_R); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    classic(1'b1, 32'h0, 32'hA5A5_0000, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL reset_first_lat: got %0d expected 1", lat); end
  endtask

  task automatic preload();
    logic [31:0] rd; int lat;
    for (int w = 0; w < 64; w++) classic(1'b1, 32'(w * 4), $urandom, 4'hF, rd, lat);
  endtask

  task automatic test_classic();
    logic [31:0] rd; int lat; int w;
    classic(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL classic_wr_lat: got %0d expected 1", lat); end
    classic(1'b1, 32'h40, 32'h0000_1234, 4'b0011, rd, lat);
    classic(1'b0, 32'h40, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL classic_rd_lat: got %0d expected 1", lat); end
    checks++; if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL classic_rd_data: got %h expected DEAD1234", rd); end
    for (int i = 0; i < 16; i++) begin
      w = $urandom_range(0, 63);
      classic(1'b1, ($urandom & ~32'h0000_0FFC) | 32'(w * 4), $urandom, 4'($urandom_range(0, 15)), rd, lat);
      w = $urandom_range(0, 63);
      classic(1'b0, ($urandom & ~32'h0000_0FFC) | 32'(w * 4), 32'h0, 4'hF, rd, lat);
      checks++; if (rd !== ref_mem[w] || lat !== 1) begin
        errors++; $display("FAIL classic_rand w%0d: got %h lat %0d expected %h lat 1", w, rd, lat, ref_mem[w]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0; bus.ADR = 32'h40; bus.CTI = 3'b000; bus.SEL = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (bus.ACK !== 1'(c % 2)) begin errors++; $display("FAIL b2b_ack c%0d: got %b expected %b", c, bus.ACK, 1'(c % 2)); end
      if (c % 2 == 1) begin
        checks++; if (bus.DAT_R !== ref_mem[16]) begin errors++; $display("FAIL b2b_data c%0d: got %h expected %h", c, bus.DAT_R, ref_mem[16]); end
      end
      @(posedge clk); #1;
    end
    bus_idle();
  endtask

  task automatic test_linear_burst();
    logic [31:0] rd; int lat;
    for (int i = 0; i < 4; i++) classic(1'b1, 32'(16 + 4 * i), 32'h100 + 32'(i), 4'hF, rd, lat);
    burst(1'b0, 4, 0, 4, -1, 4);
    checks++; if (b_got !== 4) begin errors++; $display("FAIL lin_beats: got %0d expected 4", b_got); end
    for (int i = 0; i < b_got; i++) begin
      checks++; if (b_cyc[i] !== i + 1 || b_rd[i] !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL lin_beat%0d: got cyc %0d data %h expected cyc %0d data %h", i, b_cyc[i], b_rd[i], i + 1, 32'h100 + 32'(i));
      end
    end
    classic(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lin_idle_after: got lat %0d expected 1", lat); end
  endtask

  task automatic check_burst_read(input string nm, input int start, input int bte, input int n);
    checks++; if (b_got !== n) begin errors++; $display("FAIL %s_beats: got %0d expected %0d", nm, b_got, n); end
    for (int i = 0; i < b_got; i++) begin
      checks++; if (b_cyc[i] !== i + 1 || b_rd[i] !== ref_mem[burst_word(start, bte, i)]) begin
        errors++; $display("FAIL %s_beat%0d: got cyc %0d data %h expected cyc %0d data %h",
                           nm, i, b_cyc[i], b_rd[i], i + 1, ref_mem[burst_word(start, bte, i)]);
      end
    end
  endtask

  task automatic test_wrap_bursts();
    logic [31:0] rd; int lat; int st; int bt; int n; logic we;
    burst(1'b0, 6, 1, 4, -1, 4);
    check_burst_read("wrap4_rd", 6, 1, 4);
    for (int i = 0; i < 4; i++) b_wd[i] = $urandom;
    burst(1'b1, 6, 1, 4, -1, 4);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== b_wd[2]) begin errors++; $display("FAIL wrap4_wr_word4: got %h expected %h", rd, b_wd[2]); end
    for (int w = 4; w < 8; w++) begin
      classic(1'b0, 32'(w * 4), 32'h0, 4'hF, rd, lat);
      checks++; if (rd !== ref_mem[w]) begin errors++; $display("FAIL wrap4_wr w%0d: got %h expected %h", w, rd, ref_mem[w]); end
    end
    burst(1'b0, 13, 2, 8, -1, 8);
    check_burst_read("wrap8_rd", 13, 2, 8);
    for (int k = 0; k < 12; k++) begin
      we = 1'($urandom_range(0, 1)); st = $urandom_range(0, 47);
      bt = $urandom_range(0, 3);     n  = $urandom_range(2, 8);
      for (int i = 0; i < 16; i++) b_wd[i] = $urandom;
      burst(we, st, bt, n, -1, n);
      if (!we) check_burst_read("rand_rd", st, bt, n);
      else begin
        checks++; if (b_got !== n) begin errors++; $display("FAIL rand_wr_beats: got %0d expected %0d", b_got, n); end
      end
    end
    for (int w = 0; w < 64; w++) begin
      classic(1'b0, 32'(w * 4), 32'h0, 4'hF, rd, lat);
      checks++; if (rd !== ref_mem[w]) begin errors++; $display("FAIL readback w%0d: got %h expected %h", w, rd, ref_mem[w]); end
    end
  endtask

  task automatic test_master_wait();
    int exp_cyc [4] = '{1, 3, 4, 5};
    burst(1'b0, 4, 0, 4, 2, 4);
    checks++; if (b_got !== 4) begin errors++; $display("FAIL wait_beats: got %0d expected 4", b_got); end
    for (int i = 0; i < b_got; i++) begin
      checks++; if (b_cyc[i] !== exp_cyc[i] || b_rd[i] !== ref_mem[4 + i]) begin
        errors++; $display("FAIL wait_beat%0d: got cyc %0d data %h expected cyc %0d data %h", i, b_cyc[i], b_rd[i], exp_cyc[i], ref_mem[4 + i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat;
    for (int i = 0; i < 4; i++) classic(1'b1, 32'((20 + i) * 4), 32'h5000 + 32'(i), 4'hF, rd, lat);
    for (int i = 0; i < 4; i++) b_wd[i] = $urandom;
    burst(1'b1, 20, 0, 4, -1, 2);
    checks++; if (b_got !== 2) begin errors++; $display("FAIL abort_beats: got %0d expected 2", b_got); end
    classic(1'b0, 32'(40 * 4), 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL abort_next_lat: got %0d expected 1", lat); end
    for (int w = 20; w < 24; w++) begin
      classic(1'b0, 32'(w * 4), 32'h0, 4'hF, rd, lat);
      checks++; if (rd !== ref_mem[w]) begin errors++; $display("FAIL abort_word%0d: got %h expected %h", w, rd, ref_mem[w]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; int lat; logic [31:0] d [4];
    for (int i = 0; i < 4; i++) begin
      classic(1'b1, 32'((30 + i) * 4), 32'h6000 + 32'(i), 4'hF, rd, lat);
      d[i] = $urandom;
    end
    @(posedge clk); #1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1; bus.SEL = 4'hF; bus.BTE = 2'b00;
    bus.CTI = 3'b010; bus.ADR = 32'(30 * 4); bus.DAT_W = d[0];
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.DAT_W = d[i];
      @(negedge clk);
      checks++; if (bus.ACK !== 1'b1) begin errors++; $display("FAIL rstmid_beat%0d: got ack %b expected 1", i, bus.ACK); end
      @(posedge clk); #1;
      ref_mem[30 + i] = d[i];
    end
    bus.DAT_W = d[2];
    #1;
    checks++; if (bus.ACK !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ack: got %b expected 1", bus.ACK); end
    rst = 1'b1;
    #1;
    checks++; if (bus.ACK !== 1'b0) begin errors++; $display("FAIL rstmid_ack_drop: got %b expected 0", bus.ACK); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.DAT_R !== 32'h0) begin errors++; $display("FAIL rstmid_datr: got %h expected 0", bus.DAT_R); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    for (int w = 30; w < 34; w++) begin
      classic(1'b0, 32'(w * 4), 32'h0, 4'hF, rd, lat);
      checks++; if (rd !== ref_mem[w]) begin errors++; $display("FAIL rstmid_word%0d: got %h expected %h", w, rd, ref_mem[w]); end
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    preload();
    test_classic();
    test_back_to_back();
    test_linear_burst();
    test_wrap_bursts();
    test_master_wait();
    test_abort();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1, "timeout");
  end
endmodule
